systolic_deskew: RTL and testbench

Output-side realignment stage for the systolic MAC array. The input-side delay lines stagger operand lanes so lane i enters i cycles after lane 0. This block removes that stagger from the array's result lanes and reassembles each result row into one wide word. Aligned rows go into a small first-word-fall-through FIFO, which drains over a valid/ready interface toward writeback. Alignment or capacity faults raise sticky flags.

---
 rtl/systolic_deskew.sv | 133 +++++++++++++
 tb/tb_systolic_deskew.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_deskew.sv
// systolic_deskew: removes the per-lane input stagger from the MAC array's
// result lanes, reassembles each row into one wide word, and queues complete
// rows in a small first-word-fall-through FIFO toward writeback.

// One result lane's deskew delay line: data and valid travel together and
// advance every cycle with no stall.
module systolic_deskew_lane #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             v,
  output logic [WIDTH-1:0] q,
  output logic             qv
);

  logic [STAGES:1]            vld_pipe;
  logic [STAGES:1][WIDTH-1:0] dat_pipe;

  // Free-running shift of valid and data; stage STAGES is the aligned slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= v;
      dat_pipe[1] <= d;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign q  = dat_pipe[STAGES];
  assign qv = vld_pipe[STAGES];

endmodule

module systolic_deskew #(
  parameter int WIDTH      = 32,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [LANES*WIDTH-1:0]        din,
  input  logic [LANES-1:0]              valid_in,
  input  logic                          ready_in,
  input  logic                          clear_err,
  output logic [LANES*WIDTH-1:0]        dout,
  output logic                          valid_out,
  output logic                          overflow,
  output logic                          align_err,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int DW = LANES * WIDTH;

  // Aligned slot: last register of every lane.
  logic [LANES-1:0][WIDTH-1:0] a_dat;
  logic [LANES-1:0]            a_vld;

  // Lane i arrives i cycles late, so it gets LANES-i stages to line up with lane 0.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    systolic_deskew_lane #(
      .WIDTH  (WIDTH),
      .STAGES (LANES - i)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (din[i*WIDTH +: WIDTH]),
      .v       (valid_in[i]),
      .q       (a_dat[i]),
      .qv      (a_vld[i])
    );
  end

  logic row_full, row_part;
  assign row_full = &a_vld;
  assign row_part = (|a_vld) & ~row_full;

  logic [FIFO_DEPTH-1:0][DW-1:0] mem;
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic                          full, pop, push, drop;

  assign full      = (level == LW'(FIFO_DEPTH));
  assign valid_out = (level != '0);
  assign pop       = valid_out & ready_in;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = row_full & (~full | pop);
  assign drop      = row_full & full & ~pop;
  assign dout      = mem[rd_ptr];

  // FIFO storage, pointers (wrap modulo depth) and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= a_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky fault flags; a new event takes priority over clear_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      align_err <= 1'b0;
    end else begin
      if (drop)           overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (row_part)       align_err <= 1'b1;
      else if (clear_err) align_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_deskew.sv
// Bench for systolic_deskew: per-lane input schedule arrays drive the DUT; a
// row-level queue model (rows rebuilt from the input schedule) predicts outputs.
module tb_systolic_deskew;
  localparam int W  = 32;
  localparam int L  = 4;
  localparam int D  = 4;
  localparam int DW = L * W;
  localparam int N  = 2048;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] din;
  logic [L-1:0]  valid_in;
  logic          ready_in, clear_err;
  logic [DW-1:0] dout;
  logic          valid_out, overflow, align_err;
  logic [2:0]    level;

  systolic_deskew #(.WIDTH(W), .LANES(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .valid_in(valid_in),
    .ready_in(ready_in), .clear_err(clear_err), .dout(dout),
    .valid_out(valid_out), .overflow(overflow), .align_err(align_err),
    .level(level)
  );

  always #5 clk = ~clk;

  bit            lv [N][L];
  logic [W-1:0]  ld [N][L];
  int            cyc, base;
  logic [DW-1:0] q[$];
  bit            m_ovf, m_aerr;
  int            tests, fails;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_sched();
    for (int c = 0; c < N; c++)
      for (int i = 0; i < L; i++) begin
        lv[c][i] = 1'b0;
        ld[c][i] = '0;
      end
  endtask

  // Row whose lane 0 enters at cycle c; lane i carries dbase+i at cycle c+i.
  task automatic sched(input int c, input logic [W-1:0] dbase, input logic [L-1:0] mask);
    for (int i = 0; i < L; i++)
      if (mask[i] && c + i < N) begin
        lv[c+i][i] = 1'b1;
        ld[c+i][i] = dbase + W'(i);
      end
  endtask

  // One clock edge: drive this cycle's lanes, update the model, check outputs.
  task automatic tick();
    bit            pop, push, evo, eva;
    int            k, idx;
    logic [L-1:0]  av;
    logic [DW-1:0] row;
    for (int i = 0; i < L; i++) begin
      din[i*W +: W] = ld[cyc][i];
      valid_in[i]   = lv[cyc][i];
    end
    @(posedge clk);
    pop = (q.size() > 0) && ready_in;
    k   = cyc - L;
    av  = '0;
    row = '0;
    for (int i = 0; i < L; i++) begin
      idx = k + i;
      if (idx >= base) begin
        av[i]         = lv[idx][i];
        row[i*W +: W] = ld[idx][i];
      end
    end
    push = 1'b0; evo = 1'b0; eva = 1'b0;
    if (&av) begin
      if (q.size() == D && !pop) evo = 1'b1;
      else push = 1'b1;
    end else if (|av) eva = 1'b1;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(row);
    m_ovf  = evo ? 1'b1 : (clear_err ? 1'b0 : m_ovf);
    m_aerr = eva ? 1'b1 : (clear_err ? 1'b0 : m_aerr);
    #1;
    chk("valid_out", DW'(valid_out), DW'(q.size() != 0));
    chk("level", DW'(level), DW'(q.size()));
    chk("overflow", DW'(overflow), DW'(m_ovf));
    chk("align_err", DW'(align_err), DW'(m_aerr));
    if (q.size() != 0) chk("dout", dout, q[0]);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int s;
    tests = 0; fails = 0;
    clear_sched();
    din = '0; valid_in = '0; ready_in = 1'b1; clear_err = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_valid_out", DW'(valid_out), '0);
    chk("rst_level", DW'(level), '0);
    chk("rst_dout", dout, '0);
    chk("rst_flags", DW'({overflow, align_err}), '0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    cyc = 0; base = 0; m_ovf = 0; m_aerr = 0;

    // Single row: 0x100+i on lane i.
    s = cyc;
    sched(s, 32'h100, 4'hF);
    run(5);
    chk("single_dout", dout, {32'h103, 32'h102, 32'h101, 32'h100});
    chk("single_vld", DW'(valid_out), DW'(1));
    run(1);
    chk("single_gone", DW'({valid_out, level}), '0);
    run(2);

    // 16 rows back to back, ready held high.
    s = cyc;
    for (int r = 0; r < 16; r++) sched(s + r, W'(r * 16), 4'hF);
    run(24);
    chk("stream_flags", DW'({overflow, align_err}), '0);

    // Backpressure: 6 rows into a 4-deep FIFO.
    ready_in = 1'b0;
    s = cyc;
    for (int r = 0; r < 6; r++) sched(s + r, W'(32'h1000 + r * 16), 4'hF);
    run(L + 5);
    chk("bp_level", DW'(level), DW'(4));
    chk("bp_ovf", DW'(overflow), DW'(1));
    run(3);
    clear_err = 1'b1; run(1); clear_err = 1'b0;

    // Full FIFO, pop coincides with a complete row.
    s = cyc;
    sched(s, 32'h2000, 4'hF);
    run(L);
    ready_in = 1'b1;
    run(1);
    chk("fullpp_level", DW'(level), DW'(4));
    chk("fullpp_ovf", DW'(overflow), DW'(0));
    run(8);

    // Misaligned middle row (lane 2 withheld).
    s = cyc;
    sched(s, 32'h3000, 4'hF);
    sched(s + 1, 32'h3010, 4'b1011);
    sched(s + 2, 32'h3020, 4'hF);
    run(L + 3);
    chk("mis_aerr", DW'(align_err), DW'(1));
    clear_err = 1'b1; run(1); clear_err = 1'b0;
    chk("mis_clear", DW'(align_err), DW'(0));
    run(3);

    // Reset with two rows queued and one in flight.
    ready_in = 1'b0;
    s = cyc;
    sched(s, 32'h4000, 4'hF);
    sched(s + 1, 32'h4010, 4'hF);
    run(L + 2);
    sched(cyc, 32'h4020, 4'hF);
    run(2);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_valid_out", DW'(valid_out), '0);
    chk("mrst_level", DW'(level), '0);
    chk("mrst_flags", DW'({overflow, align_err}), '0);
    q.delete(); m_ovf = 0; m_aerr = 0;
    clear_sched();
    #1 reset_n = 1'b1;
    base = cyc;
    ready_in = 1'b1;
    sched(cyc, 32'h5000, 4'hF);
    run(L + 1);
    chk("post_rst_dout", dout, {32'h5003, 32'h5002, 32'h5001, 32'h5000});
    run(3);

    // Randomized traffic: skewed rows, occasional lane drops, random backpressure.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(1, 0) == 1)
        sched(cyc, W'($urandom), ($urandom_range(7, 0) == 0) ? L'($urandom) : 4'hF);
      ready_in  = ($urandom_range(3, 0) != 0);
      clear_err = ($urandom_range(15, 0) == 0);
      tick();
    end
    clear_err = 1'b0; ready_in = 1'b1;
    run(L + D + 2);
    chk("drain_level", DW'(level), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
